fetch_ctrl_unit: RTL and testbench

Sequencing controller that drives the instruction read unit of the 8-bit CPU and consumes its instruction output. It drives PC enable, PC source select, memory read and IR load, and decodes the fetched byte. It resolves jumps by loading the PC directly, and hands non-control instructions to the execute datapath over a valid/ready handshake. It is the control-side counterpart of the instruction read unit: that unit obeys these strobes and returns instructions; this block issues the strobes and consumes the instructions.

---
 rtl/cpu8_pkg.sv | 26 ++
 rtl/fetch_ctrl_unit_if.sv | 31 +++
 rtl/cpu8_op_class.sv | 20 ++
 rtl/fetch_ctrl_unit.sv | 96 +++++++++
 tb/tb_fetch_ctrl_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU fetch/sequencing logic:
// opcode constants, FSM state encoding and the opcode-class record.
package cpu8_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic is_jmp;
        logic is_jz;
        logic is_hlt;
        logic is_nop;
        logic is_exec;
    } op_class_t;

endpackage

// File: rtl/fetch_ctrl_unit_if.sv
// Handshake/strobe bundle between the fetch controller, the instruction
// read unit and the execute datapath.
interface fetch_ctrl_unit_if;

    logic       start_i;
    logic [7:0] instr_i;
    logic       zero_i;
    logic       exec_ready_i;
    logic       imen_o;
    logic       iren_o;
    logic       pcen_o;
    logic       mod_o;
    logic [3:0] addr_o;
    logic       exec_valid_o;
    logic [3:0] op_o;
    logic [3:0] opd_o;
    logic       halted_o;

    modport master (
        input  start_i, instr_i, zero_i, exec_ready_i,
        output imen_o, iren_o, pcen_o, mod_o, addr_o,
               exec_valid_o, op_o, opd_o, halted_o
    );

    modport slave (
        output start_i, instr_i, zero_i, exec_ready_i,
        input  imen_o, iren_o, pcen_o, mod_o, addr_o,
               exec_valid_o, op_o, opd_o, halted_o
    );

endinterface

// File: rtl/cpu8_op_class.sv
// Combinational opcode classifier: exactly one class bit is set per opcode;
// anything that is not a control opcode belongs to the execute class.
module cpu8_op_class
    import cpu8_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class         = '0;
        o_class.is_nop  = (i_opcode == OP_NOP);
        o_class.is_jmp  = (i_opcode == OP_JMP);
        o_class.is_jz   = (i_opcode == OP_JZ);
        o_class.is_hlt  = (i_opcode == OP_HLT);
        o_class.is_exec = !(o_class.is_nop || o_class.is_jmp ||
                            o_class.is_jz  || o_class.is_hlt);
    end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// Fetch/decode sequencer: issues PC/memory/IR strobes to the instruction read
// unit, resolves jumps locally and offers other ops to execute via valid/ready.
module fetch_ctrl_unit
    import cpu8_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    fetch_ctrl_unit_if.master  bus
);

    state_t     r_state;
    logic [3:0] r_op;
    logic [3:0] r_opd;

    op_class_t  w_cls;
    logic       w_taken;
    logic       w_imen;
    logic       w_iren;
    logic       w_pcen;
    logic       w_mod;
    logic [3:0] w_addr;
    logic       w_valid;
    logic       w_halted;

    cpu8_op_class u_op_class (
        .i_opcode (bus.instr_i[7:4]),
        .o_class  (w_cls)
    );

    assign w_taken = w_cls.is_jmp || (w_cls.is_jz && bus.zero_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_op    <= 4'h0;
            r_opd   <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) r_state <= ST_FETCH;
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_op  <= bus.instr_i[7:4];
                    r_opd <= bus.instr_i[3:0];
                    if (w_cls.is_hlt)       r_state <= ST_HALT;
                    else if (w_cls.is_exec) r_state <= ST_EXEC;
                    else                    r_state <= ST_FETCH;
                end
                ST_EXEC: begin
                    if (bus.exec_ready_i) r_state <= ST_FETCH;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so reset clears them without a clock edge.
    always_comb begin
        w_imen   = 1'b0;
        w_iren   = 1'b0;
        w_pcen   = 1'b0;
        w_mod    = 1'b0;
        w_addr   = 4'h0;
        w_valid  = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imen = 1'b1;
                w_iren = 1'b1;
            end
            ST_DECODE: begin
                w_pcen = w_cls.is_nop || w_cls.is_jmp || w_cls.is_jz || w_cls.is_exec;
                if (w_taken) begin
                    w_mod  = 1'b1;
                    w_addr = bus.instr_i[3:0];
                end
            end
            ST_EXEC:  w_valid  = 1'b1;
            ST_HALT:  w_halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.imen_o       = w_imen;
    assign bus.iren_o       = w_iren;
    assign bus.pcen_o       = w_pcen;
    assign bus.mod_o        = w_mod;
    assign bus.addr_o       = w_addr;
    assign bus.exec_valid_o = w_valid;
    assign bus.op_o         = r_op;
    assign bus.opd_o        = r_opd;
    assign bus.halted_o     = w_halted;

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Self-checking bench for fetch_ctrl_unit: table-driven instruction vectors,
// an op/operand scoreboard for the execute handshake, and reset/halt sequences.
module tb_fetch_ctrl_unit;

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        logic       is_exec;
        int         stall;
        logic       exp_pcen;
        logic       exp_mod;
        logic [3:0] exp_addr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    logic [7:0] sb_q[$];
    vec_t vecs[10];

    fetch_ctrl_unit_if bus();

    fetch_ctrl_unit dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [17:0] all_outs();
        return {bus.imen_o, bus.iren_o, bus.pcen_o, bus.mod_o, bus.addr_o,
                bus.exec_valid_o, bus.op_o, bus.opd_o, bus.halted_o};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered and left at a negedge with the DUT in FETCH.
    task automatic run_instr(input vec_t v);
        int t0;
        logic [7:0] exp;
        check("fetch_imen", 32'(bus.imen_o), 32'd1);
        check("fetch_iren", 32'(bus.iren_o), 32'd1);
        t0 = cyc;
        bus.instr_i      = v.instr;
        bus.zero_i       = v.zero;
        bus.exec_ready_i = 1'b1;
        step();
        check($sformatf("dec_pcen_%02h", v.instr), 32'(bus.pcen_o), 32'(v.exp_pcen));
        check($sformatf("dec_mod_%02h", v.instr),  32'(bus.mod_o),  32'(v.exp_mod));
        check($sformatf("dec_addr_%02h", v.instr), 32'(bus.addr_o), 32'(v.exp_addr));
        check($sformatf("dec_valid_%02h", v.instr), 32'(bus.exec_valid_o), 32'd0);
        if (v.is_exec) sb_q.push_back(v.instr);
        step();
        if (v.is_exec) begin
            for (int s = 0; s <= v.stall; s++) begin
                bus.exec_ready_i = (s == v.stall);
                check("exec_valid", 32'(bus.exec_valid_o), 32'd1);
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp = sb_q[0];
                    check("exec_op_opd", 32'({bus.op_o, bus.opd_o}), 32'(exp));
                    if (s == v.stall) void'(sb_q.pop_front());
                end
                step();
            end
            bus.exec_ready_i = 1'b0;
            check("exec_dropped", 32'(bus.exec_valid_o), 32'd0);
        end
        check($sformatf("interval_%02h", v.instr), 32'(cyc - t0),
              v.is_exec ? 32'(3 + v.stall) : 32'd2);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.instr_i = 8'h00;
        bus.zero_i = 1'b0;
        bus.exec_ready_i = 1'b0;

        //          instr  zero exec stall pcen mod addr
        vecs[0] = '{8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 4'h0};
        vecs[1] = '{8'h8A, 1'b0, 1'b0, 0, 1'b1, 1'b1, 4'hA};
        vecs[2] = '{8'h93, 1'b0, 1'b0, 0, 1'b1, 1'b0, 4'h0};
        vecs[3] = '{8'h93, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4'h3};
        vecs[4] = '{8'h25, 1'b0, 1'b1, 4, 1'b1, 1'b0, 4'h0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 0, 1'b1, 1'b0, 4'h0};
        vecs[6] = '{8'h05, 1'b1, 1'b0, 0, 1'b1, 1'b0, 4'h0};
        vecs[7] = '{8'h8F, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4'hF};
        vecs[8] = '{8'hE1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 4'h0};
        vecs[9] = '{8'h70, 1'b0, 1'b1, 1, 1'b1, 1'b0, 4'h0};

        // Reset held, then released with start low.
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(all_outs()), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_outs", 32'(all_outs()), 32'd0);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;

        for (int i = 0; i < 10; i++) run_instr(vecs[i]);

        // HLT: strobes stay off and start pulses are ignored.
        bus.instr_i = 8'hF0;
        step();
        check("hlt_dec_pcen", 32'(bus.pcen_o), 32'd0);
        check("hlt_dec_mod", 32'(bus.mod_o), 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            check("halt_halted", 32'(bus.halted_o), 32'd1);
            check("halt_strobes", 32'({bus.imen_o, bus.iren_o, bus.pcen_o, bus.exec_valid_o}), 32'd0);
            bus.start_i = i[0];
            bus.instr_i = 8'($urandom_range(0, 255));
            bus.exec_ready_i = 1'b1;
            step();
        end
        bus.start_i = 1'b0;
        bus.exec_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("halt_async_reset", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_halt_idle", 32'(all_outs()), 32'd0);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;

        // Reset while an op is being offered.
        check("mid_fetch", 32'(bus.imen_o), 32'd1);
        bus.instr_i = 8'h47;
        bus.zero_i = 1'b0;
        bus.exec_ready_i = 1'b0;
        step();
        step();
        check("mid_valid", 32'(bus.exec_valid_o), 32'd1);
        check("mid_op_opd", 32'({bus.op_o, bus.opd_o}), 32'h47);
        step();
        check("mid_valid_hold", 32'(bus.exec_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_valid", 32'(bus.exec_valid_o), 32'd0);
        check("mid_reset_op", 32'({bus.op_o, bus.opd_o}), 32'd0);
        check("mid_reset_outs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        run_instr(vecs[0]);
        run_instr(vecs[4]);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
